ascon_fsm_ctrl: RTL and testbench
=================================

// Module: ascon_fsm_ctrl
// PURPOSE
//  Sequencing controller for the ASCON-128 round datapath (mux, xor_begin, pc/ps/pl, xor_end, 320b state reg).
//  Drives the round index, mux select, the four xor enables and the state-register enable, one round per clock.
//  Runs one full encryption: init(pa), AD blocks(pb), PT blocks(pb), final(pa), tag.
//  Accepts 64b blocks over a valid/ready handshake; data and key buses go straight to the datapath.
// PARAMETERS
//  PA_ROUNDS  12  rounds for init/final; round_o runs 0..PA_ROUNDS-1
//  PB_ROUNDS   6  rounds per AD/PT block; round_o runs PA_ROUNDS-PB_ROUNDS..PA_ROUNDS-1 (6..11)
//  Legal range: 1 <= PB_ROUNDS <= PA_ROUNDS <= 16.
// PORTS
//  clock_i           in   1  clock
//  resetb_i          in   1  synchronous, active-high reset
//  start_i           in   1  start new operation; honoured in IDLE only
//  ad_empty_i        in   1  no associated data; sampled with start_i
//  data_valid_i      in   1  data_i block valid
//  data_last_i       in   1  current block is the last of its phase (AD or PT)
//  data_ready_o      out  1  controller can absorb a block this cycle
//  round_o           out  4  round index to pc
//  data_sel_o        out  1  0: mux takes state_i (IV||K||N); 1: register feedback
//  en_xor_data_o     out  1  xor data_i into x0 before the round
//  en_xor_key_o      out  1  xor key into x1,x2 before the round (finalisation)
//  en_xor_key_end_o  out  1  xor key into x3,x4 after the round
//  en_xor_lsb_o      out  1  xor 1 into LSB of x4 after the round (domain separation)
//  en_reg_state_o    out  1  state register load
//  cipher_valid_o    out  1  ciphertext block valid this cycle (x0 after data xor)
//  tag_valid_o       out  1  state_o holds the tag (x3,x4); one-cycle pulse
//  busy_o            out  1  high from the start-accept cycle until tag_valid_o (inclusive)
// BEHAVIOUR
//  - Reset (any state, mid-op included): next state IDLE, counter 0, ad_empty flag 0; all outputs 0.
//  - States: IDLE, INIT, AD_WAIT, AD_RUN, PT_WAIT, PT_RUN, FINAL, DONE. Mealy: the accept cycle runs the first round.
//  - IDLE: start_i=1 -> round 0, data_sel=0, en_reg=1, latch ad_empty_i; -> INIT (counter=1). Else all outputs 0.
//  - INIT: round=counter, data_sel=1, en_reg=1. Last round (PA-1): en_xor_key_end=1.
//    If ad_empty latched, en_xor_lsb=1 in the same cycle and -> PT_WAIT; else -> AD_WAIT.
//  - AD_WAIT / PT_WAIT: data_ready=1, en_reg=0 while data_valid=0. No timeout.
//  - AD_WAIT & data_valid: round=PA-PB, data_sel=1, en_xor_data=1, en_reg=1; latch data_last_i; -> AD_RUN.
//  - AD_RUN: rounds PA-PB+1..PA-1, en_reg=1. Last round: en_xor_lsb=1 only if the latched last flag is set.
//    Then -> PT_WAIT if last, else -> AD_WAIT.
//  - PT_WAIT & data_valid & !data_last: round=PA-PB, en_xor_data=1, cipher_valid=1, en_reg=1; -> PT_RUN.
//    PT_RUN runs the remaining rounds, then -> PT_WAIT.
//  - PT_WAIT & data_valid & data_last: round=0, en_xor_data=1, en_xor_key=1, cipher_valid=1, en_reg=1; -> FINAL.
//    The last block arrives already padded; >=1 PT block is mandatory.
//  - FINAL: rounds 1..PA-1, en_reg=1. Round PA-1: en_xor_key_end=1; -> DONE.
//  - DONE: tag_valid=1, en_reg=0, busy=1 for one cycle; -> IDLE. start_i in DONE is ignored.
//  - data_valid_i outside a WAIT state is ignored (data_ready=0), never buffered.
//    start_i outside IDLE is ignored.
//  - Counter: 4b, reloaded on every accept; wraps only via reload, never by overflow.
//  - en_reg_state=0 holds the state register (stall-safe).
//  - Latency, start-accept to tag_valid: PA + nAD*PB + (nPT-1)*PB + PA + waits, where waits are the WAIT cycles.
//    With zero-wait valid: 12+6nAD+6(nPT-1)+12 cycles.
// STRUCTURE
//  - ascon_pack gains: typedef enum logic[2:0] type_ctrl_state {IDLE..DONE};
//    localparams PA_ROUNDS_C=12, PB_ROUNDS_C=6, PB_START_C=4'd6.
//  - One sub-module, ascon_round_counter: 4b, load value, enable, last_o when count==PA-1.
//  - The FSM uses one registered state plus a combinational output decode; all outputs derive from state,
//    counter and inputs, with no output registers.
// TESTING
//  1. Reset during FINAL round 5, then resetb_i=0 -> all outputs 0 next cycle. A new start gives round_o=0, data_sel_o=0.
//  2. start, ad_empty=0, 1 AD block, 1 PT(last), valid always high -> en_reg high for 30 cycles.
//     round_o: 0..11, 6..11, 0..11. tag_valid pulses in cycle 31.
//  3. ad_empty=1 -> en_xor_key_end_o and en_xor_lsb_o both 1 at INIT round 11. No AD_WAIT is visited.
//  4. 2 AD + 3 PT blocks, valid withheld 3 cycles before each block.
//     en_reg=0 and round_o stable during waits; cipher_valid pulses exactly 3 times.
//  5. Last PT accept -> one cycle with en_xor_data=en_xor_key=cipher_valid=1 and round_o=0.
//     en_xor_key_end=1 at round 11 only.
//  6. data_valid_i high during INIT, start_i high during AD_RUN -> no effect on state, counter or outputs.
//  Compare state_o against the ASCON-128 reference KAT (key 000102..0F, nonce 000102..0F, empty AD/PT) for the tag.

Source files
------------

// File: rtl/ascon_fsm_ctrl_pkg.sv
// Shared types and constants for the ASCON-128 round sequencing controller.
// Provides the controller state encoding and the default round counts.
package ascon_fsm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD_WAIT,
    AD_RUN,
    PT_WAIT,
    PT_RUN,
    FINAL,
    DONE
  } type_ctrl_state;

  localparam int unsigned PA_ROUNDS_C = 12;
  localparam int unsigned PB_ROUNDS_C = 6;
  localparam logic [3:0]  PB_START_C  = 4'd6;

endpackage

// File: rtl/ascon_round_counter.sv
// 4-bit round counter for the ASCON controller.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset (count -> 0)
//   load     in  load load_val (has priority over en)
//   load_val in  value to load
//   en       in  increment by one
//   count    out current round count
//   last_o   out count equals LAST_VAL (final round of a permutation)
module ascon_round_counter #(
  parameter int unsigned LAST_VAL = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] count,
  output logic       last_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign last_o = (count == 4'(LAST_VAL));

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// Sequencing controller for the ASCON-128 round datapath: one round per clock
// through init (pa), AD blocks (pb), PT blocks (pb), finalisation (pa), tag.
// Ports:
//   clock_i, resetb_i (sync, active-high)
//   start_i, ad_empty_i            operation start / no-AD flag (sampled in IDLE)
//   data_valid_i, data_last_i      block handshake in, data_ready_o out
//   round_o                        round index to the constant-addition layer
//   data_sel_o                     0: load IV||K||N, 1: register feedback
//   en_xor_data_o, en_xor_key_o    pre-round xors
//   en_xor_key_end_o, en_xor_lsb_o post-round xors
//   en_reg_state_o                 state register load
//   cipher_valid_o, tag_valid_o, busy_o
module ascon_fsm_ctrl
  import ascon_fsm_ctrl_pkg::*;
#(
  parameter int unsigned PA_ROUNDS = PA_ROUNDS_C,
  parameter int unsigned PB_ROUNDS = PB_ROUNDS_C
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       ad_empty_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       data_sel_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_reg_state_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  localparam logic [3:0] PB_START = 4'(PA_ROUNDS - PB_ROUNDS);
  // Counter value after a block-accept round; unused when PB_ROUNDS == 1.
  localparam logic [3:0] PB_NEXT  = 4'(PA_ROUNDS - PB_ROUNDS + 1);

  type_ctrl_state state, state_n;
  logic           ad_empty_q, ad_empty_n;
  logic           ad_last_q, ad_last_n;
  logic           cnt_load, cnt_en, cnt_last;
  logic [3:0]     cnt_val, cnt;

  ascon_round_counter #(
    .LAST_VAL(PA_ROUNDS - 1)
  ) u_round_counter (
    .clk     (clock_i),
    .rst     (resetb_i),
    .load    (cnt_load),
    .load_val(cnt_val),
    .en      (cnt_en),
    .count   (cnt),
    .last_o  (cnt_last)
  );

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state      <= IDLE;
      ad_empty_q <= 1'b0;
      ad_last_q  <= 1'b0;
    end else begin
      state      <= state_n;
      ad_empty_q <= ad_empty_n;
      ad_last_q  <= ad_last_n;
    end
  end

  always_comb begin
    state_n          = state;
    ad_empty_n       = ad_empty_q;
    ad_last_n        = ad_last_q;
    cnt_load         = 1'b0;
    cnt_val          = '0;
    cnt_en           = 1'b0;
    data_ready_o     = 1'b0;
    round_o          = '0;
    data_sel_o       = 1'b0;
    en_xor_data_o    = 1'b0;
    en_xor_key_o     = 1'b0;
    en_xor_key_end_o = 1'b0;
    en_xor_lsb_o     = 1'b0;
    en_reg_state_o   = 1'b0;
    cipher_valid_o   = 1'b0;
    tag_valid_o      = 1'b0;
    busy_o           = 1'b0;

    // Every non-IDLE state is busy, feeds back the register and shows the
    // counter; accept cycles below override round_o with the block start.
    if (state != IDLE) begin
      busy_o     = 1'b1;
      data_sel_o = 1'b1;
      round_o    = cnt;
    end

    case (state)
      IDLE: begin
        if (start_i) begin
          busy_o         = 1'b1;
          en_reg_state_o = 1'b1;
          ad_empty_n     = ad_empty_i;
          cnt_load       = 1'b1;
          cnt_val        = 4'd1;
          // A single-round pa makes the accept round the last init round.
          if (PA_ROUNDS == 1) begin
            en_xor_key_end_o = 1'b1;
            en_xor_lsb_o     = ad_empty_i;
            state_n          = ad_empty_i ? PT_WAIT : AD_WAIT;
          end else begin
            state_n = INIT;
          end
        end
      end

      INIT: begin
        en_reg_state_o = 1'b1;
        if (cnt_last) begin
          en_xor_key_end_o = 1'b1;
          en_xor_lsb_o     = ad_empty_q;
          state_n          = ad_empty_q ? PT_WAIT : AD_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end

      AD_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          round_o        = PB_START;
          en_xor_data_o  = 1'b1;
          en_reg_state_o = 1'b1;
          ad_last_n      = data_last_i;
          cnt_load       = 1'b1;
          cnt_val        = PB_NEXT;
          if (PB_ROUNDS == 1) begin
            en_xor_lsb_o = data_last_i;
            state_n      = data_last_i ? PT_WAIT : AD_WAIT;
          end else begin
            state_n = AD_RUN;
          end
        end
      end

      AD_RUN: begin
        en_reg_state_o = 1'b1;
        if (cnt_last) begin
          en_xor_lsb_o = ad_last_q;
          state_n      = ad_last_q ? PT_WAIT : AD_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end

      PT_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_xor_data_o  = 1'b1;
          cipher_valid_o = 1'b1;
          en_reg_state_o = 1'b1;
          cnt_load       = 1'b1;
          if (data_last_i) begin
            // Last PT block runs straight into finalisation round 0.
            round_o      = '0;
            en_xor_key_o = 1'b1;
            cnt_val      = 4'd1;
            if (PA_ROUNDS == 1) begin
              en_xor_key_end_o = 1'b1;
              state_n          = DONE;
            end else begin
              state_n = FINAL;
            end
          end else begin
            round_o = PB_START;
            cnt_val = PB_NEXT;
            state_n = (PB_ROUNDS == 1) ? PT_WAIT : PT_RUN;
          end
        end
      end

      PT_RUN: begin
        en_reg_state_o = 1'b1;
        if (cnt_last) begin
          state_n = PT_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end

      FINAL: begin
        en_reg_state_o = 1'b1;
        if (cnt_last) begin
          en_xor_key_end_o = 1'b1;
          state_n          = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      DONE: begin
        tag_valid_o = 1'b1;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Outputs stay quiet for the whole reset cycle, whatever the state was.
    if (resetb_i) begin
      data_ready_o     = 1'b0;
      round_o          = '0;
      data_sel_o       = 1'b0;
      en_xor_data_o    = 1'b0;
      en_xor_key_o     = 1'b0;
      en_xor_key_end_o = 1'b0;
      en_xor_lsb_o     = 1'b0;
      en_reg_state_o   = 1'b0;
      cipher_valid_o   = 1'b0;
      tag_valid_o      = 1'b0;
      busy_o           = 1'b0;
    end
  end

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Directed self-checking bench for ascon_fsm_ctrl (default 12/6 rounds).
module tb_ascon_fsm_ctrl;

  logic       clk;
  logic       resetb_i, start_i, ad_empty_i, data_valid_i, data_last_i;
  logic       data_ready_o, data_sel_o, en_xor_data_o, en_xor_key_o;
  logic       en_xor_key_end_o, en_xor_lsb_o, en_reg_state_o;
  logic       cipher_valid_o, tag_valid_o, busy_o;
  logic [3:0] round_o;
  logic [13:0] act;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_en     = 0;
  int n_cv     = 0;

  localparam logic [13:0] MASK_ALL  = 14'h3FFF;
  localparam logic [13:0] MASK_DONE = 14'h20FF;

  ascon_fsm_ctrl dut (
    .clock_i         (clk),
    .resetb_i        (resetb_i),
    .start_i         (start_i),
    .ad_empty_i      (ad_empty_i),
    .data_valid_i    (data_valid_i),
    .data_last_i     (data_last_i),
    .data_ready_o    (data_ready_o),
    .round_o         (round_o),
    .data_sel_o      (data_sel_o),
    .en_xor_data_o   (en_xor_data_o),
    .en_xor_key_o    (en_xor_key_o),
    .en_xor_key_end_o(en_xor_key_end_o),
    .en_xor_lsb_o    (en_xor_lsb_o),
    .en_reg_state_o  (en_reg_state_o),
    .cipher_valid_o  (cipher_valid_o),
    .tag_valid_o     (tag_valid_o),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ready, round[3:0], sel, xdata, xkey, xkeyend, lsb, reg, cipher, tag, busy}
  assign act = {data_ready_o, round_o, data_sel_o, en_xor_data_o, en_xor_key_o,
                en_xor_key_end_o, en_xor_lsb_o, en_reg_state_o, cipher_valid_o,
                tag_valid_o, busy_o};

  function automatic logic [13:0] ov(input logic rdy, input logic [3:0] rnd,
                                     input logic sel, input logic xd, input logic xk,
                                     input logic xke, input logic lsb, input logic rg,
                                     input logic cv, input logic tv, input logic bsy);
    return {rdy, rnd, sel, xd, xk, xke, lsb, rg, cv, tv, bsy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_m(input string tag, input logic [13:0] exp, input logic [13:0] mask);
    cyc++;
    if (act[3]) n_en++;
    if (act[2]) n_cv++;
    n_checks++;
    assert ((act & mask) === (exp & mask)) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b mask=%b", tag, act, exp, mask);
    end
  endtask

  task automatic chk(input string tag, input logic [13:0] exp);
    chk_m(tag, exp, MASK_ALL);
  endtask

  task automatic chk_v(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start-accept cycle plus init rounds 1..11; data_valid held high to show it is ignored.
  task automatic run_start(input logic empty, input string tag);
    step();
    start_i = 1'b1; ad_empty_i = empty; data_valid_i = 1'b1; data_last_i = 1'b0;
    #4;
    cyc = 0; n_en = 0; n_cv = 0;
    chk({tag, "_start"}, ov(0, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    for (int r = 1; r <= 11; r++) begin
      step();
      start_i = 1'b0; ad_empty_i = 1'b0; data_valid_i = 1'b1;
      #4;
      chk({tag, "_init"}, ov(0, 4'(r), 1, 0, 0, r == 11, (r == 11) && empty, 1, 0, 0, 1));
    end
  endtask

  // nwait idle cycles, then the accept; non-final blocks also run rounds 7..11
  // with start_i and data_valid_i held high to show they are ignored.
  task automatic block(input logic pt, input logic last, input int unsigned nwait,
                       input string tag);
    for (int unsigned w = 0; w < nwait; w++) begin
      step();
      data_valid_i = 1'b0; data_last_i = last;
      #4;
      chk({tag, "_wait"}, ov(1, 4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    step();
    data_valid_i = 1'b1; data_last_i = last;
    #4;
    if (pt && last) begin
      chk({tag, "_acc_last"}, ov(1, 4'd0, 1, 1, 1, 0, 0, 1, 1, 0, 1));
    end else begin
      chk({tag, "_acc"}, ov(1, 4'd6, 1, 1, 0, 0, 0, 1, pt, 0, 1));
      for (int r = 7; r <= 11; r++) begin
        step();
        data_valid_i = 1'b1; start_i = 1'b1;
        #4;
        chk({tag, "_run"}, ov(0, 4'(r), 1, 0, 0, 0, (r == 11) && !pt && last, 1, 0, 0, 1));
      end
      start_i = 1'b0;
    end
  endtask

  // Finalisation rounds 1..11, tag cycle, then back to idle.
  task automatic run_final(input string tag, input int exp_en, input int exp_cyc);
    for (int r = 1; r <= 11; r++) begin
      step();
      data_valid_i = 1'b1; data_last_i = 1'b1;
      #4;
      chk({tag, "_final"}, ov(0, 4'(r), 1, 0, 0, r == 11, 0, 1, 0, 0, 1));
    end
    step();
    start_i = 1'b1; data_valid_i = 1'b0;
    #4;
    chk_m({tag, "_done"}, ov(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1), MASK_DONE);
    chk_v({tag, "_tag_cycle"}, cyc, exp_cyc);
    chk_v({tag, "_en_reg_cycles"}, n_en, exp_en);
    step();
    start_i = 1'b0;
    #4;
    chk({tag, "_idle"}, ov(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb_i = 1'b1; start_i = 1'b0; ad_empty_i = 1'b0;
    data_valid_i = 1'b0; data_last_i = 1'b0;
    step(); step();
    step();
    resetb_i = 1'b0;
    #4;
    chk("reset_idle", ov(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // 1 AD + 1 PT(last), valid always high.
    run_start(1'b0, "t2");
    block(1'b0, 1'b1, 0, "t2_ad");
    block(1'b1, 1'b1, 0, "t2_pt");
    run_final("t2", 30, 31);

    // No AD: lsb with key_end at init round 11, next accept is a PT accept.
    run_start(1'b1, "t3");
    block(1'b1, 1'b1, 0, "t3_pt");
    run_final("t3", 24, 25);

    // 2 AD + 3 PT with 3 wait cycles before each block.
    run_start(1'b0, "t4");
    block(1'b0, 1'b0, 3, "t4_ad0");
    block(1'b0, 1'b1, 3, "t4_ad1");
    block(1'b1, 1'b0, 3, "t4_pt0");
    block(1'b1, 1'b0, 3, "t4_pt1");
    block(1'b1, 1'b1, 3, "t4_pt2");
    run_final("t4", 48, 64);
    chk_v("t4_cipher_pulses", n_cv, 3);

    // Reset during finalisation round 5, then restart.
    run_start(1'b0, "t1");
    block(1'b0, 1'b1, 0, "t1_ad");
    block(1'b1, 1'b1, 0, "t1_pt");
    for (int r = 1; r <= 4; r++) begin
      step();
      data_valid_i = 1'b0;
      #4;
      chk("t1_final", ov(0, 4'(r), 1, 0, 0, 0, 0, 1, 0, 0, 1));
    end
    step();
    resetb_i = 1'b1;
    step();
    resetb_i = 1'b0;
    #4;
    chk("t1_after_reset", ov(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    start_i = 1'b1; ad_empty_i = 1'b0;
    #4;
    chk("t1_restart", ov(0, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    step();
    start_i = 1'b0;
    #4;
    chk("t1_restart_r1", ov(0, 4'd1, 1, 0, 0, 0, 0, 1, 0, 0, 1));
    step();
    resetb_i = 1'b1;
    step();
    resetb_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
